// File: rtl/pe_gen_pkg.sv
// Shared types and constants for the Generations-capable processing element.
//   pe_cmd_t     : command encoding driven by the array controller
//   age_act_e    : what the rule logic asks the age counter to do on PROCESS
//   PE_STATE_*   : fixed state codes (dying states are 2..N_STATES-1)
//   RULE_BITS    : width of one outer-totalistic mask (neighbour counts 0..8)
package pe_gen_pkg;

   localparam int unsigned PE_STATE_DEAD = 0;
   localparam int unsigned PE_STATE_LIVE = 1;
   localparam int unsigned RULE_BITS     = 9;

   typedef enum logic [2:0] {
      NOP       = 3'd0,
      PROCESS   = 3'd1,
      WRITE     = 3'd2,
      READ      = 3'd3,
      LOAD_RULE = 3'd4,
      CLR_AGE   = 3'd5
   } pe_cmd_t;

   typedef enum logic [1:0] {
      AgeHold,
      AgeInc,
      AgeClr
   } age_act_e;

endpackage

// File: rtl/pe_gen_rule.sv
// Combinational next-state rule for one cell.
//   state_i     : current cell state
//   nc_i        : live-neighbour count, 0..8
//   birth_i     : birth mask, bit n set => n neighbours cause birth
//   survive_i   : survive mask, bit n set => live cell with n neighbours survives
//   nstate_o    : state after a PROCESS
//   age_act_o   : age counter action for that PROCESS
module pe_gen_rule
   import pe_gen_pkg::*;
#(
   parameter int unsigned STATE_BITS = 4,
   parameter int unsigned N_STATES   = 2
) (
   input  logic [STATE_BITS-1:0] state_i,
   input  logic [3:0]            nc_i,
   input  logic [RULE_BITS-1:0]  birth_i,
   input  logic [RULE_BITS-1:0]  survive_i,
   output logic [STATE_BITS-1:0] nstate_o,
   output age_act_e              age_act_o
);

   localparam logic [STATE_BITS-1:0] StDead = STATE_BITS'(PE_STATE_DEAD);
   localparam logic [STATE_BITS-1:0] StLive = STATE_BITS'(PE_STATE_LIVE);
   // First dying state when decay is enabled; plain Life dies straight to DEAD.
   localparam logic [STATE_BITS-1:0] StDie  = (N_STATES > 2) ? STATE_BITS'(2) : StDead;

   always_comb begin
      nstate_o  = state_i;
      age_act_o = AgeHold;
      if (state_i == StDead) begin
         if (birth_i[nc_i]) begin
            nstate_o  = StLive;
            age_act_o = AgeClr;
         end
      end else if (state_i == StLive) begin
         if (survive_i[nc_i]) begin
            age_act_o = AgeInc;
         end else begin
            nstate_o  = StDie;
            age_act_o = AgeClr;
         end
      end else begin
         // Dying cells ignore neighbours and step towards DEAD; age stays at 0.
         if (32'(state_i) + 32'd1 >= N_STATES) begin
            nstate_o = StDead;
         end else begin
            nstate_o = state_i + STATE_BITS'(1);
         end
      end
   end

endmodule

// File: rtl/pe_gen.sv
// One cell of the tiled array: rule-programmable Life/Generations PE with age counter.
//   clk, rst_n            : clock and asynchronous active-low reset
//   rsel_i, csel_i        : row/column select qualifying WRITE, READ and LOAD_RULE
//   vga_rsel, vga_csel    : row/column select for the VGA readout path
//   cmd                   : pe_cmd_t command
//   state_in, rule_in     : WRITE data, {birth, survive} for LOAD_RULE
//   w_i .. se_i           : neighbour live flags
//   status_out            : 1 iff the cell is LIVE (dying cells excluded)
//   state_out, age_out    : registered READ data, zero when not read
//   vga_out               : registered VGA data, zero when not selected
//   active                : combinational, this cycle changes state or age
module pe_gen
   import pe_gen_pkg::*;
#(
   parameter int unsigned          STATE_BITS  = 4,
   parameter int unsigned          N_STATES    = 2,
   parameter int unsigned          AGE_BITS    = 8,
   parameter logic [RULE_BITS-1:0] BIRTH_RST   = 9'h008,
   parameter logic [RULE_BITS-1:0] SURVIVE_RST = 9'h00C
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rsel_i,
   input  logic                   csel_i,
   input  logic                   vga_rsel,
   input  logic                   vga_csel,
   input  logic [2:0]             cmd,
   input  logic [STATE_BITS-1:0]  state_in,
   input  logic [2*RULE_BITS-1:0] rule_in,
   input  logic                   w_i,
   input  logic                   e_i,
   input  logic                   n_i,
   input  logic                   s_i,
   input  logic                   nw_i,
   input  logic                   ne_i,
   input  logic                   sw_i,
   input  logic                   se_i,
   output logic                   status_out,
   output logic [STATE_BITS-1:0]  state_out,
   output logic [AGE_BITS-1:0]    age_out,
   output logic [STATE_BITS-1:0]  vga_out,
   output logic                   active
);

   logic [STATE_BITS-1:0] state_q, state_d;
   logic [AGE_BITS-1:0]   age_q, age_d;
   logic [RULE_BITS-1:0]  birth_q, birth_d;
   logic [RULE_BITS-1:0]  survive_q, survive_d;
   logic [STATE_BITS-1:0] state_out_d, vga_out_d;
   logic [AGE_BITS-1:0]   age_out_d;

   logic                  sel, vga_sel, read_en;
   pe_cmd_t               cmd_e;
   logic [3:0]            nc;
   logic [STATE_BITS-1:0] rule_nstate;
   age_act_e              rule_age_act;

   assign cmd_e   = pe_cmd_t'(cmd);
   assign sel     = rsel_i & csel_i;
   assign vga_sel = vga_rsel & vga_csel;
   assign read_en = (cmd_e == READ) && sel;

   assign nc = {3'b0, w_i} + {3'b0, e_i} + {3'b0, n_i} + {3'b0, s_i}
             + {3'b0, nw_i} + {3'b0, ne_i} + {3'b0, sw_i} + {3'b0, se_i};

   pe_gen_rule #(
      .STATE_BITS (STATE_BITS),
      .N_STATES   (N_STATES)
   ) u_rule (
      .state_i   (state_q),
      .nc_i      (nc),
      .birth_i   (birth_q),
      .survive_i (survive_q),
      .nstate_o  (rule_nstate),
      .age_act_o (rule_age_act)
   );

   always_comb begin
      state_d   = state_q;
      age_d     = age_q;
      birth_d   = birth_q;
      survive_d = survive_q;
      case (cmd_e)
         PROCESS: begin
            state_d = rule_nstate;
            case (rule_age_act)
               AgeInc:  age_d = (age_q == '1) ? age_q : age_q + AGE_BITS'(1);
               AgeClr:  age_d = '0;
               default: age_d = age_q;
            endcase
         end
         WRITE: begin
            if (sel) begin
               // Out-of-range codes would otherwise park the cell in an undefined state.
               state_d = (32'(state_in) < N_STATES) ? state_in : STATE_BITS'(PE_STATE_DEAD);
               age_d   = '0;
            end
         end
         LOAD_RULE: begin
            if (sel) begin
               birth_d   = rule_in[2*RULE_BITS-1:RULE_BITS];
               survive_d = rule_in[RULE_BITS-1:0];
            end
         end
         CLR_AGE: age_d = '0;
         default: ;
      endcase
   end

   always_comb begin
      state_out_d = read_en ? state_q : '0;
      age_out_d   = read_en ? age_q : '0;
      vga_out_d   = vga_sel ? state_q : '0;
   end

   assign active     = (state_d != state_q) || (age_d != age_q);
   assign status_out = (state_q == STATE_BITS'(PE_STATE_LIVE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= STATE_BITS'(PE_STATE_DEAD);
         age_q     <= '0;
         birth_q   <= BIRTH_RST;
         survive_q <= SURVIVE_RST;
         state_out <= '0;
         age_out   <= '0;
         vga_out   <= '0;
      end else begin
         state_q   <= state_d;
         age_q     <= age_d;
         birth_q   <= birth_d;
         survive_q <= survive_d;
         state_out <= state_out_d;
         age_out   <= age_out_d;
         vga_out   <= vga_out_d;
      end
   end

endmodule

// File: tb/tb_pe_gen.sv
// Bench for pe_gen: two instances share stimulus -- a Life cell with a 2-bit age
// counter (index 0) and a 4-state Generations cell with an 8-bit age (index 1).
module tb_pe_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rsel, csel, vrsel, vcsel;
   logic [2:0]  cmd;
   logic [3:0]  state_in;
   logic [17:0] rule_in;
   logic [7:0]  nbr;

   logic        st_a, st_g, act_a, act_g;
   logic [3:0]  so_a, so_g, vo_a, vo_g;
   logic [1:0]  ao_a;
   logic [7:0]  ao_g;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pe_gen #(.STATE_BITS(4), .N_STATES(2), .AGE_BITS(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .rsel_i(rsel), .csel_i(csel),
      .vga_rsel(vrsel), .vga_csel(vcsel), .cmd(cmd), .state_in(state_in), .rule_in(rule_in),
      .w_i(nbr[0]), .e_i(nbr[1]), .n_i(nbr[2]), .s_i(nbr[3]),
      .nw_i(nbr[4]), .ne_i(nbr[5]), .sw_i(nbr[6]), .se_i(nbr[7]),
      .status_out(st_a), .state_out(so_a), .age_out(ao_a), .vga_out(vo_a), .active(act_a)
   );

   pe_gen #(.STATE_BITS(4), .N_STATES(4), .AGE_BITS(8)) dut_g (
      .clk(clk), .rst_n(rst_n), .rsel_i(rsel), .csel_i(csel),
      .vga_rsel(vrsel), .vga_csel(vcsel), .cmd(cmd), .state_in(state_in), .rule_in(rule_in),
      .w_i(nbr[0]), .e_i(nbr[1]), .n_i(nbr[2]), .s_i(nbr[3]),
      .nw_i(nbr[4]), .ne_i(nbr[5]), .sw_i(nbr[6]), .se_i(nbr[7]),
      .status_out(st_g), .state_out(so_g), .age_out(ao_g), .vga_out(vo_g), .active(act_g)
   );

   // Reference model, one slot per instance.
   int          ns_cfg[2]   = '{2, 4};
   int          amax_cfg[2] = '{3, 255};
   int          m_st[2];
   int          m_age[2];
   logic [8:0]  m_b[2];
   logic [8:0]  m_s[2];

   typedef struct {
      int d;
      int so;
      int ao;
      int vo;
      int stat;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_st[d]  = 0;
         m_age[d] = 0;
         m_b[d]   = 9'h008;
         m_s[d]   = 9'h00C;
      end
   endtask

   // Called just after a falling edge: drives one command, checks active, predicts the
   // registered outputs, then compares them after the next rising edge.
   task automatic step(input logic [2:0] c, input logic [1:0] s, input logic [1:0] vs,
                       input logic [7:0] nb, input logic [3:0] si, input logic [17:0] ri);
      int   nc, ns, na;
      logic sel;
      logic [8:0] nbm, nsm;
      exp_t e;
      cmd = c;
      {rsel, csel} = s;
      {vrsel, vcsel} = vs;
      nbr = nb;
      state_in = si;
      rule_in = ri;
      #1;
      nc  = $countones(nb);
      sel = &s;
      for (int d = 0; d < 2; d++) begin
         ns  = m_st[d];
         na  = m_age[d];
         nbm = m_b[d];
         nsm = m_s[d];
         case (c)
            3'd1: begin
               if (m_st[d] == 0) begin
                  if (m_b[d][nc]) begin
                     ns = 1;
                     na = 0;
                  end
               end else if (m_st[d] == 1) begin
                  if (m_s[d][nc]) begin
                     na = (m_age[d] < amax_cfg[d]) ? m_age[d] + 1 : m_age[d];
                  end else begin
                     ns = (ns_cfg[d] > 2) ? 2 : 0;
                     na = 0;
                  end
               end else begin
                  ns = (m_st[d] + 1 == ns_cfg[d]) ? 0 : m_st[d] + 1;
               end
            end
            3'd2: if (sel) begin
               ns = (int'(si) < ns_cfg[d]) ? int'(si) : 0;
               na = 0;
            end
            3'd4: if (sel) begin
               nbm = ri[17:9];
               nsm = ri[8:0];
            end
            3'd5: na = 0;
            default: ;
         endcase
         if (d == 0) chk("active_a", int'(act_a), int'((ns != m_st[d]) || (na != m_age[d])));
         else        chk("active_g", int'(act_g), int'((ns != m_st[d]) || (na != m_age[d])));
         e.d    = d;
         e.so   = (c == 3'd3 && sel) ? m_st[d] : 0;
         e.ao   = (c == 3'd3 && sel) ? m_age[d] : 0;
         e.vo   = (&vs) ? m_st[d] : 0;
         e.stat = (ns == 1) ? 1 : 0;
         sb.push_back(e);
         m_st[d]  = ns;
         m_age[d] = na;
         m_b[d]   = nbm;
         m_s[d]   = nsm;
      end
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.d == 0) begin
            chk("state_out_a", int'(so_a), e.so);
            chk("age_out_a", int'(ao_a), e.ao);
            chk("vga_out_a", int'(vo_a), e.vo);
            chk("status_a", int'(st_a), e.stat);
         end else begin
            chk("state_out_g", int'(so_g), e.so);
            chk("age_out_g", int'(ao_g), e.ao);
            chk("vga_out_g", int'(vo_g), e.vo);
            chk("status_g", int'(st_g), e.stat);
         end
      end
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_status_a"}, int'(st_a), 0);
      chk({tag, "_state_a"}, int'(so_a), 0);
      chk({tag, "_age_a"}, int'(ao_a), 0);
      chk({tag, "_vga_a"}, int'(vo_a), 0);
      chk({tag, "_status_g"}, int'(st_g), 0);
      chk({tag, "_state_g"}, int'(so_g), 0);
      chk({tag, "_age_g"}, int'(ao_g), 0);
      chk({tag, "_vga_g"}, int'(vo_g), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   localparam logic [2:0] C_NOP = 3'd0, C_PROC = 3'd1, C_WR = 3'd2, C_RD = 3'd3,
                          C_LR = 3'd4, C_CLR = 3'd5;
   localparam logic [7:0] NC0 = 8'h00, NC2 = 8'b0001_0001, NC2B = 8'b0100_0010,
                          NC3 = 8'b1010_0100, NC4 = 8'b1111_0000;

   initial begin
      rst_n = 1'b0;
      {rsel, csel, vrsel, vcsel} = 4'b0;
      cmd = C_NOP; state_in = '0; rule_in = '0; nbr = '0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      model_reset();

      // Life: birth, survive with ageing, overcrowding death
      step(C_PROC, 2'b00, 2'b00, NC3, 4'h0, 18'h0);
      step(C_PROC, 2'b00, 2'b00, NC2, 4'h0, 18'h0);
      step(C_RD, 2'b11, 2'b00, NC0, 4'h0, 18'h0);
      chk("life_age_lit", int'(ao_g), 1);
      chk("life_state_lit", int'(so_a), 1);
      step(C_PROC, 2'b00, 2'b11, NC4, 4'h0, 18'h0);

      // Generations decay with VGA tracking
      step(C_WR, 2'b11, 2'b11, NC0, 4'h1, 18'h0);
      for (int i = 0; i < 3; i++) step(C_PROC, 2'b00, 2'b11, NC0, 4'h0, 18'h0);
      step(C_NOP, 2'b00, 2'b11, NC0, 4'h0, 18'h0);

      // Rule load: unselected is ignored, selected takes effect next PROCESS
      step(C_LR, 2'b10, 2'b00, NC2, 4'h0, {9'h00C, 9'h00C});
      step(C_PROC, 2'b00, 2'b00, NC2, 4'h0, 18'h0);
      step(C_LR, 2'b11, 2'b00, NC2, 4'h0, {9'h00C, 9'h00C});
      step(C_PROC, 2'b00, 2'b00, NC2B, 4'h0, 18'h0);

      // Age saturation and clear
      for (int i = 0; i < 5; i++) step(C_PROC, 2'b00, 2'b00, NC2, 4'h0, 18'h0);
      step(C_RD, 2'b11, 2'b00, NC0, 4'h0, 18'h0);
      chk("age_sat_lit", int'(ao_a), 3);
      step(C_CLR, 2'b00, 2'b00, NC0, 4'h0, 18'h0);
      step(C_RD, 2'b11, 2'b00, NC0, 4'h0, 18'h0);
      chk("age_clr_lit", int'(ao_g), 0);

      // Write/read paths, out-of-range write, unselected read, undefined commands
      step(C_WR, 2'b11, 2'b00, NC0, 4'hF, 18'h0);
      step(C_WR, 2'b11, 2'b00, NC0, 4'h3, 18'h0);
      step(C_RD, 2'b11, 2'b00, NC0, 4'h0, 18'h0);
      chk("wr_range_lit_g", int'(so_g), 3);
      chk("wr_range_lit_a", int'(so_a), 0);
      step(C_RD, 2'b01, 2'b00, NC0, 4'h0, 18'h0);
      step(C_WR, 2'b01, 2'b11, NC0, 4'h1, 18'h0);
      step(3'd6, 2'b11, 2'b11, NC3, 4'h1, 18'h0);
      step(3'd7, 2'b11, 2'b10, NC3, 4'h1, 18'h0);

      // Async reset in the middle of a PROCESS with nonzero outputs beforehand
      step(C_WR, 2'b11, 2'b11, NC0, 4'h1, 18'h0);
      step(C_RD, 2'b11, 2'b11, NC0, 4'h0, 18'h0);
      cmd = C_PROC;
      nbr = NC0;
      {vrsel, vcsel} = 2'b11;
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_rst");
      @(posedge clk);
      #1;
      chk_all_zero("rst_hold");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // Reset restores B3/S23 after the earlier B23 load
      step(C_PROC, 2'b00, 2'b00, NC2, 4'h0, 18'h0);
      step(C_PROC, 2'b00, 2'b11, NC3, 4'h0, 18'h0);
      step(C_NOP, 2'b00, 2'b11, NC0, 4'h0, 18'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
